// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface mdu_sequencer_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      mulctr;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, mulctr, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, mulctr, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative radix-2 shift-add multiply / restoring divide for RV64M, one bit per cycle.
// Result is held in DONE until taken; flush kills any operation without touching the result.
module mdu_sequencer #(
  parameter int XLEN = 64,
  parameter int CNTW = 7
) (
  input  logic           clk,
  input  logic           rst,
  mdu_sequencer_if.slave bus
);
  localparam int HALF = XLEN / 2;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;

  logic dq_div, dq_rem, dq_w, dq_s1, dq_s2, dq_high;
  logic in_code_ok, in_w, in_sext;

  assign dq_div  = op_q[2];
  assign dq_rem  = op_q[2] & op_q[1];
  assign dq_w    = op_q[3] & (op_q != 4'b1001);
  assign dq_s1   = dq_div ? ~op_q[0] : (op_q != 4'b0011);
  assign dq_s2   = dq_div ? ~op_q[0] : (op_q == 4'b1001 || op_q == 4'b0001 || op_q == 4'b1000);
  assign dq_high = ~op_q[3] & ~op_q[2] & (op_q[1:0] != 2'b00);

  assign in_code_ok = !(bus.mulctr == 4'b0000 || bus.mulctr == 4'b1010 || bus.mulctr == 4'b1011);
  assign in_w       = bus.mulctr[3] & (bus.mulctr != 4'b1001);
  assign in_sext    = in_w & ~(bus.mulctr[2] & bus.mulctr[0]);

  assign bus.in_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;

  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     rem_sh, diff, mul_sum;
  logic [2*XLEN-1:0] div_step, mul_step, prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opb_d    = opb_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    sa    = dq_s1 & a_q[XLEN-1];
    sb    = dq_s2 & b_q[XLEN-1];
    mag_a = sa ? -a_q : a_q;
    mag_b = sb ? -b_q : b_q;

    // Divide keeps remainder in the upper half and dividend/quotient in the lower half of acc.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = rem_sh - {1'b0, opb_q};
    div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // A half-width multiply only runs HALF shifts, so its product sits HALF bits up.
    prod    = dq_w ? (acc_q >> HALF) : acc_q;
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_raw = dq_div  ? (dq_rem ? rem_s : quo_s)
            : dq_high ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    fix_res = dq_w ? {{HALF{fix_raw[HALF-1]}}, fix_raw[HALF-1:0]} : fix_raw;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_code_ok && !bus.flush) begin
          op_d    = bus.mulctr;
          a_d     = !in_w   ? bus.src1
                  : in_sext ? {{HALF{bus.src1[HALF-1]}}, bus.src1[HALF-1:0]}
                            : {{HALF{1'b0}}, bus.src1[HALF-1:0]};
          b_d     = !in_w   ? bus.src2
                  : in_sext ? {{HALF{bus.src2[HALF-1]}}, bus.src2[HALF-1:0]}
                            : {{HALF{1'b0}}, bus.src2[HALF-1:0]};
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d = dq_w ? CNTW'(HALF) : CNTW'(XLEN);
        neg_d = dq_rem ? sa : (sa ^ sb);
        if (dq_div) begin
          opb_d = mag_b;
          acc_d = {{XLEN{1'b0}}, (dq_w ? (mag_a << HALF) : mag_a)};
          if (b_q == '0) begin
            result_d = !dq_rem ? {XLEN{1'b1}}
                     : dq_w    ? {{HALF{a_q[HALF-1]}}, a_q[HALF-1:0]} : a_q;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          opb_d   = mag_a;
          acc_d   = {{XLEN{1'b0}}, mag_b};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = dq_div ? div_step : mul_step;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opb_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and random operations against an arithmetic reference; a negedge monitor
// pops the scoreboard on every result handshake and checks value, latency and stability.
module tb_mdu_sequencer;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.XLEN(XLEN)) bus ();
  mdu_sequencer #(.XLEN(XLEN), .CNTW(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic        rdy_force = 1'b0;
  logic        rdy_rand = 1'b1;
  bit          mon_seen = 1'b0;
  logic [63:0] mon_held = '0;

  logic [3:0] codes [13] = '{4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                             4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_rand = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
  end
  assign bus.out_ready = (rdy_mode == 2) ? rdy_force : rdy_rand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural meaning of each op, computed with wide native arithmetic.
  function automatic logic [63:0] ref_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  wa, wb, wq;
    logic [31:0]         ua, ub, t;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (c)
      4'b1001: return a * b;
      4'b0001: begin pa = sa; pb = sb; ps = pa * pb; return ps[127:64]; end
      4'b0010: begin pa = sa; pb = {64'd0, b}; ps = pa * pb; return ps[127:64]; end
      4'b0011: begin pu = {64'd0, a} * {64'd0, b}; return pu[127:64]; end
      4'b0100: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        sq = sa / sb; return sq;
      end
      4'b0101: return (b == 0) ? '1 : a / b;
      4'b0110: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        sq = sa % sb; return sq;
      end
      4'b0111: return (b == 0) ? a : a % b;
      4'b1000: begin t = ua * ub; return sext32(t); end
      4'b1100: begin
        if (ub == 0) return '1;
        if (ua == 32'h8000_0000 && ub == '1) return sext32(ua);
        wq = wa / wb; return sext32(wq);
      end
      4'b1101: begin if (ub == 0) return '1; t = ua / ub; return sext32(t); end
      4'b1110: begin
        if (ub == 0) return sext32(ua);
        if (ua == 32'h8000_0000 && ub == '1) return 64'd0;
        wq = wa % wb; return sext32(wq);
      end
      4'b1111: begin if (ub == 0) return sext32(ua); t = ua % ub; return sext32(t); end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [63:0] b);
    bit w;
    w = c[3] && (c != 4'b1001);
    if (c[2] && (w ? (b[31:0] == 0) : (b == 0))) return 2;
    return w ? 35 : 67;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, 32'h8000_0000};
      5: return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drives one request and pushes its expectation; returns one cycle after the accept edge.
  task automatic send_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
    exp_t e;
    int   n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
      return;
    end
    bus.in_valid = 1'b1; bus.mulctr = c; bus.src1 = a; bus.src2 = b;
    e.res = exp; e.lat = ref_lat(c, b); e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mulctr = 4'b0000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: got none expected %h (cycle %0d)", sb_q[0].res, cyc);
      sb_q.delete();
      mon_seen = 1'b0;
    end
  endtask

  task automatic run_vec(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
    send_op(c, a, b, exp);
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() != 0 && cyc > sb_q[0].acc_cyc) check("busy_during_op", 64'(bus.busy), 64'd1);
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          if (!mon_seen) begin
            check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
            mon_seen = 1'b1;
            mon_held = bus.result;
          end else begin
            check("result_stable", bus.result, mon_held);
          end
          check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
          if (bus.out_ready && !bus.flush) begin
            check("result", bus.result, sb_q[0].res);
            void'(sb_q.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  c;
    logic [63:0] a, b;
    int          n;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.mulctr = 4'b0000; bus.src1 = '0; bus.src2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.mulctr = (i == 0) ? 4'b0000 : (i == 1) ? 4'b1010 : 4'b1011;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.mulctr = 4'b0000;
      @(negedge clk);
      check("ignored_code_busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
    end

    run_vec(4'b1001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    run_vec(4'b0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    run_vec(4'b0011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_vec(4'b0010, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_vec(4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_vec(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_vec(4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run_vec(4'b1110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
    run_vec(4'b0101, 64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_vec(4'b0111, 64'h1234, 64'd0, 64'h1234);
    run_vec(4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    run_vec(4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0);
    run_vec(4'b1111, 64'hABCD_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001);

    // Backpressure: hold the result in DONE for five cycles.
    rdy_mode = 2; rdy_force = 1'b0;
    send_op(4'b1001, 64'd5, 64'd7, 64'd35);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    @(negedge clk);
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_idle_busy", 64'(bus.busy), 64'd0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Flush at the tenth CALC cycle, then an immediate mulw.
    send_op(4'b1001, 64'h1234_5678, 64'h9ABC_DEF0, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    run_vec(4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

    // Synchronous reset in the middle of a divide.
    send_op(4'b0100, 64'h0123_4567_89AB_CDEF, 64'd77, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_result", bus.result, 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 12)];
      a = pick();
      b = pick();
      run_vec(c, a, b, ref_model(c, a, b));
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide sequencer for the RV64M datapath, driven by the 4-bit MULctr code the decoder produces.
- Accepts one operation with two 64-bit operands over a valid/ready handshake and runs a radix-2 shift-add multiply or restoring divide.
- Returns the selected 64-bit result over a second valid/ready handshake. The execute stage stalls while busy is high.

Parameters:
XLEN, 64, operand/result width; word (W) ops use XLEN/2.
CNTW, 7, iteration counter width; must hold XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous kill of any operation in flight
in_valid  input  1  operation request
in_ready  output  1  sequencer can accept (state IDLE)
mulctr  input  4  op code: 1001 mul, 0001 mulh, 0010 mulhsu, 0011 mulhu, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw; 0000 none
src1  input  XLEN  rs1 value
src2  input  XLEN  rs2 value
out_valid  output  1  result available (state DONE)
out_ready  input  1  consumer takes result
result  output  XLEN  final result
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; out_valid=0, busy=0, result=0, counter=0, all internal registers 0.
- States: IDLE, PREP, CALC, FIX, DONE.
- in_ready = (state==IDLE) && !flush.
- Accept = in_valid && in_ready && mulctr!=0000. Codes 0000, 1010, 1011 and other unlisted codes are ignored: no state change.
- IDLE -> PREP on accept. Latch op, src1 and src2. For W ops latch the low 32 bits only, sign- or zero-extended per op.
- PREP, one cycle:
  - Signedness: mul, mulh, div, rem, mulw, divw, remw treat both operands as signed. mulhsu treats src1 signed and src2 unsigned. Unsigned ops treat both as unsigned.
  - Take magnitudes of the signed operands. Record the result sign: product/quotient = sign1 XOR sign2; remainder = sign1.
  - Load counter with N = XLEN, or XLEN/2 for W ops.
  - If a divide/remainder op has divisor==0 (low 32 bits for W ops), go to DONE with: quotient all ones; remainder = dividend (W: sign-extended low 32 bits). Otherwise go to CALC.
- CALC, N cycles, one iteration per cycle:
  - Multiply: 2N-bit accumulator, add multiplicand if the multiplier LSB is 1, shift right.
  - Divide: restoring; shift the remainder left, trial-subtract, set the quotient bit.
  - Counter decrements each cycle; go to FIX when counter==1 on the edge.
- FIX, one cycle:
  - Negate the product, quotient or remainder when its recorded sign is 1.
  - Select: low XLEN bits for mul; high XLEN bits for mulh, mulhsu, mulhu; quotient for div/divu; remainder for rem/remu.
  - W ops: sign-extend bit 31 of the 32-bit result to 64 bits, for unsigned W ops as well.
  - Register result; go to DONE.
- DONE: out_valid=1 and result held stable until out_valid && out_ready, then go to IDLE. in_ready stays 0 during DONE, so no same-cycle re-accept.
- Latency from accept edge to out_valid high: N+3 cycles (67 for 64-bit ops, 35 for W ops); 2 cycles for divide-by-zero.
- Signed overflow (most-negative / -1) needs no special path: quotient = dividend, remainder = 0, via the magnitude algorithm.
- flush in any state: next state IDLE, out_valid=0, result unchanged, operation discarded. flush has priority over accept and over out_ready.
- rst has priority over flush and clears mid-operation state identically to power-up.

Test Plan:
- mul src1=3, src2=0xFFFF_FFFF_FFFF_FFFB -> result 0xFFFF_FFFF_FFFF_FFF1; out_valid exactly 67 cycles after accept; busy high throughout.
- mulh src1=src2=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000. mulhu with src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
- div with src1=-7, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD. rem with the same operands -> 0xFFFF_FFFF_FFFF_FFFF. divw with src1=0x8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; remw with the same operands -> 0. W ops produce out_valid 35 cycles after accept.
- divu with src2=0 -> 0xFFFF_FFFF_FFFF_FFFF, out_valid 2 cycles after accept. remu with src1=0x1234, src2=0 -> 0x1234.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; result is taken on the out_ready cycle, then IDLE and in_ready=1 the next cycle.
- Flush at CALC cycle 10 -> IDLE next cycle with out_valid never asserted; a following mulw accepted at once on src1=0x7FFF_FFFF, src2=2 -> 0xFFFF_FFFF_FFFF_FFFE. Assert rst in CALC -> all outputs at reset values next cycle.
